// File: rtl/lcd_pkg.sv
// Shared types for the 8080-style LCD bus writer: FSM states and the FIFO entry layout.
package lcd_pkg;

    localparam int LCD_DW = 16;

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        IDLE,
        SETUP,
        WR_LOW,
        WR_HIGH,
        HOLD,
        CS_REL
    } lcd_state_t;

    typedef struct packed {
        logic              last;
        logic              is_cmd;
        logic [LCD_DW-1:0] data;
    } lcd_entry_t;

    localparam int ENTRY_W = $bits(lcd_entry_t);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_word_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on rd_data and the consumer registers it on pop.
module lcd_word_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

endmodule

// File: rtl/lcd_bus_writer.sv
// Drives an ILI9341-style 8080 write-only bus from a command/data word stream,
// after running the panel hardware-reset sequence.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int WR_LOW_CYC   = 2,
    parameter int WR_HIGH_CYC  = 2,
    parameter int RST_LOW_CYC  = 500,
    parameter int RST_WAIT_CYC = 6000000,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LCD_DW-1:0] in_data,
    input  logic              in_is_cmd,
    input  logic              in_last,
    output logic              init_busy,
    output logic              lcd_csx,
    output logic              lcd_dcx,
    output logic              lcd_wrx,
    output logic              lcd_rdx,
    output logic [LCD_DW-1:0] lcd_data_out,
    output logic              lcd_reset
);

    localparam int CNT_MAX = max_int(max_int(WR_LOW_CYC, WR_HIGH_CYC),
                                     max_int(RST_LOW_CYC, RST_WAIT_CYC));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FCW     = $clog2(FIFO_DEPTH + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t RST_LOW_LOAD  = cnt_t'(RST_LOW_CYC - 1);
    localparam cnt_t RST_WAIT_LOAD = cnt_t'(RST_WAIT_CYC - 1);
    localparam cnt_t WR_LOW_LOAD   = cnt_t'(WR_LOW_CYC - 1);
    localparam cnt_t WR_HIGH_LOAD  = cnt_t'(WR_HIGH_CYC - 1);

    lcd_state_t        state_reg;
    cnt_t              cnt_reg;
    logic              last_reg;
    logic              init_busy_reg;
    logic              csx_reg;
    logic              dcx_reg;
    logic              wrx_reg;
    logic              rdx_reg;
    logic              lcd_reset_reg;
    logic [LCD_DW-1:0] data_reg;

    lcd_entry_t        push_entry;
    lcd_entry_t        head_entry;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCW-1:0]    fifo_count;

    assign push_entry = '{last: in_last, is_cmd: in_is_cmd, data: in_data};
    assign head_entry = fifo_rd_data;

    // Ready depends only on registered state, never on in_valid.
    assign in_ready  = !fifo_full && !init_busy_reg;
    assign fifo_push = in_valid && in_ready;

    // Pop points: IDLE, HOLD and a back-to-back continuation at the end of WR_HIGH.
    assign fifo_pop = !fifo_empty &&
                      ((state_reg == IDLE) || (state_reg == HOLD) ||
                       ((state_reg == WR_HIGH) && (cnt_reg == '0) && !last_reg));

    lcd_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wr_data (push_entry),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= RST_LOW;
            cnt_reg       <= RST_LOW_LOAD;
            last_reg      <= 1'b0;
            init_busy_reg <= 1'b1;
            csx_reg       <= 1'b1;
            dcx_reg       <= 1'b1;
            wrx_reg       <= 1'b1;
            rdx_reg       <= 1'b1;
            lcd_reset_reg <= 1'b0;
            data_reg      <= '0;
        end else begin
            rdx_reg <= 1'b1;
            case (state_reg)
                RST_LOW: begin
                    if (cnt_reg == '0) begin
                        state_reg     <= RST_WAIT;
                        cnt_reg       <= RST_WAIT_LOAD;
                        lcd_reset_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - cnt_t'(1);
                    end
                end
                RST_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg     <= IDLE;
                        init_busy_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - cnt_t'(1);
                    end
                end
                IDLE: begin
                    if (fifo_pop) begin
                        state_reg <= SETUP;
                        csx_reg   <= 1'b0;
                        data_reg  <= head_entry.data;
                        dcx_reg   <= !head_entry.is_cmd;
                        last_reg  <= head_entry.last;
                    end
                end
                SETUP: begin
                    state_reg <= WR_LOW;
                    wrx_reg   <= 1'b0;
                    cnt_reg   <= WR_LOW_LOAD;
                end
                WR_LOW: begin
                    if (cnt_reg == '0) begin
                        state_reg <= WR_HIGH;
                        wrx_reg   <= 1'b1;
                        cnt_reg   <= WR_HIGH_LOAD;
                    end else begin
                        cnt_reg <= cnt_reg - cnt_t'(1);
                    end
                end
                WR_HIGH: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - cnt_t'(1);
                    end else if (last_reg) begin
                        state_reg <= CS_REL;
                        csx_reg   <= 1'b1;
                    end else if (fifo_pop) begin
                        state_reg <= SETUP;
                        data_reg  <= head_entry.data;
                        dcx_reg   <= !head_entry.is_cmd;
                        last_reg  <= head_entry.last;
                    end else begin
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (fifo_pop) begin
                        state_reg <= SETUP;
                        data_reg  <= head_entry.data;
                        dcx_reg   <= !head_entry.is_cmd;
                        last_reg  <= head_entry.last;
                    end
                end
                CS_REL: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= RST_LOW;
                end
            endcase
        end
    end

    assign init_busy    = init_busy_reg;
    assign lcd_csx      = csx_reg;
    assign lcd_dcx      = dcx_reg;
    assign lcd_wrx      = wrx_reg;
    assign lcd_rdx      = rdx_reg;
    assign lcd_data_out = data_reg;
    assign lcd_reset    = lcd_reset_reg;

    fifo_bounded: assert property (@(posedge clk) disable iff (!reset_n)
                                   fifo_count <= FCW'(FIFO_DEPTH));
    no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
                                   fifo_pop |-> !fifo_empty);

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: bus-level monitor against a word scoreboard plus directed start-up,
// burst, hold, reset-abort and randomized streaming scenarios.
module tb_lcd_bus_writer;

    localparam int WRL      = 2;
    localparam int WRH      = 2;
    localparam int RSTL     = 4;
    localparam int RSTW     = 8;
    localparam int DEPTH    = 4;
    localparam int INIT_CYC = RSTL + RSTW;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_is_cmd = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_ready, init_busy, lcd_csx, lcd_dcx, lcd_wrx, lcd_rdx, lcd_reset;
    logic [15:0] lcd_data_out;

    always #5 clk = ~clk;

    lcd_bus_writer #(
        .WR_LOW_CYC   (WRL),
        .WR_HIGH_CYC  (WRH),
        .RST_LOW_CYC  (RSTL),
        .RST_WAIT_CYC (RSTW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_is_cmd    (in_is_cmd),
        .in_last      (in_last),
        .init_busy    (init_busy),
        .lcd_csx      (lcd_csx),
        .lcd_dcx      (lcd_dcx),
        .lcd_wrx      (lcd_wrx),
        .lcd_rdx      (lcd_rdx),
        .lcd_data_out (lcd_data_out),
        .lcd_reset    (lcd_reset)
    );

    typedef struct {
        logic        is_cmd;
        logic [15:0] data;
        logic        last;
    } word_t;

    int          n_cmp = 0;
    int          n_err = 0;
    word_t       exp_q[$];
    logic [15:0] log_data[$];
    logic        log_dcx[$];
    int          log_t[$];
    int          sample_idx = 0;
    int          falls_seen = 0;
    bit          stall_seen = 0;

    // monitor state
    bit          m_prev_rst_low = 0;
    bit          m_armed = 0;
    bit          m_prev_wrx = 1;
    bit          m_open = 0;
    bit          m_need_rel = 0;
    bit          m_seen_rise = 0;
    logic        m_prev_dcx = 1'b1;
    logic [15:0] m_prev_data = 16'h0;
    int          m_k = 0;
    int          m_low_len = 0;
    int          m_high_len = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (sample %0d)", name, act, exp, sample_idx);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: condition not met (sample %0d)", name, sample_idx);
    endfunction

    // Bus monitor: samples every negedge, checks reset/start-up rules and every strobe.
    initial begin : monitor
        word_t w;
        forever begin
            @(negedge clk);
            sample_idx++;
            if (m_prev_rst_low) begin
                m_armed = 1; m_k = 0; exp_q.delete();
                m_open = 0; m_need_rel = 0; m_seen_rise = 0; m_low_len = 0; m_high_len = 0;
                check("rst_lcd_reset", lcd_reset, 0);
                check("rst_csx", lcd_csx, 1);
                check("rst_dcx", lcd_dcx, 1);
                check("rst_wrx", lcd_wrx, 1);
                check("rst_rdx", lcd_rdx, 1);
                check("rst_data", lcd_data_out, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_init_busy", init_busy, 1);
            end else if (m_armed) begin
                m_k++;
                check("rdx_high", lcd_rdx, 1);
                check("lcd_reset_seq", lcd_reset, (m_k >= RSTL));
                check("init_busy_seq", init_busy, (m_k < INIT_CYC));
                if (m_k < INIT_CYC) begin
                    check("in_ready_init", in_ready, 0);
                    check("wrx_init", lcd_wrx, 1);
                    check("csx_init", lcd_csx, 1);
                end else if (exp_q.size() == 0) begin
                    check("in_ready_empty", in_ready, 1);
                end
                if (m_prev_wrx && !lcd_wrx) begin
                    falls_seen++;
                    check("csx_at_fall", lcd_csx, 0);
                    check("data_setup", lcd_data_out, m_prev_data);
                    check("dcx_setup", lcd_dcx, m_prev_dcx);
                    check("csx_rel_before_next", m_need_rel, 0);
                    if (m_seen_rise) check("wrx_high_gap", (m_high_len >= WRH + 1), 1);
                    m_low_len = 1;
                end else if (!m_prev_wrx && !lcd_wrx) begin
                    m_low_len++;
                    check("data_stable_low", lcd_data_out, m_prev_data);
                    check("dcx_stable_low", lcd_dcx, m_prev_dcx);
                    check("csx_low_in_strobe", lcd_csx, 0);
                end else if (!m_prev_wrx && lcd_wrx) begin
                    check("wrx_low_len", m_low_len, WRL);
                    check("data_stable_rise", lcd_data_out, m_prev_data);
                    check("dcx_stable_rise", lcd_dcx, m_prev_dcx);
                    check("csx_at_rise", lcd_csx, 0);
                    if (exp_q.size() == 0) begin
                        fail_now("strobe_unexpected");
                    end else begin
                        w = exp_q.pop_front();
                        check("strobe_dcx", lcd_dcx, !w.is_cmd);
                        check("strobe_data", lcd_data_out, w.data);
                        m_need_rel = w.last;
                        m_open = !w.last;
                    end
                    log_data.push_back(lcd_data_out);
                    log_dcx.push_back(lcd_dcx);
                    log_t.push_back(sample_idx);
                    m_seen_rise = 1;
                    m_high_len = 1;
                end else begin
                    m_high_len++;
                end
                if (m_open) check("csx_held_open", lcd_csx, 0);
                if (lcd_csx) m_need_rel = 0;
                if (reset_n && in_valid && in_ready) begin
                    w.is_cmd = in_is_cmd;
                    w.data = in_data;
                    w.last = in_last;
                    exp_q.push_back(w);
                end
            end
            m_prev_rst_low = !reset_n;
            m_prev_wrx = lcd_wrx;
            m_prev_data = lcd_data_out;
            m_prev_dcx = lcd_dcx;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic c, input logic [15:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1; in_is_cmd = c; in_data = d; in_last = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stall_seen = 1;
            t++;
            if (t > 200) begin
                fail_now("push_timeout");
                break;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input string name);
        int t = 0;
        while (log_data.size() < n) begin
            @(negedge clk); #1;
            t++;
            if (t > 2000) begin
                fail_now(name);
                break;
            end
        end
        tick();
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk); #1;
            t++;
            if (t > 5000) begin
                fail_now("drain_timeout");
                break;
            end
        end
        tick();
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        int bf;
        int t;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        // start-up sequence
        repeat (3) tick();
        check("t1_reset_low_k3", lcd_reset, 0);
        tick();
        check("t1_reset_high_k4", lcd_reset, 1);
        repeat (7) tick();
        check("t1_busy_k11", init_busy, 1);
        check("t1_ready_k11", in_ready, 0);
        tick();
        check("t1_busy_k12", init_busy, 0);
        check("t1_ready_k12", in_ready, 1);

        // three-word transaction
        base = log_data.size();
        push_word(1'b1, 16'h002C, 1'b0);
        push_word(1'b0, 16'hF800, 1'b0);
        push_word(1'b0, 16'h07E0, 1'b1);
        wait_log(base + 3, "t2_timeout");
        if (log_data.size() >= base + 3) begin
            check("t2_dcx0", log_dcx[base], 0);
            check("t2_dcx1", log_dcx[base+1], 1);
            check("t2_dcx2", log_dcx[base+2], 1);
            check("t2_data0", log_data[base], 16'h002C);
            check("t2_data1", log_data[base+1], 16'hF800);
            check("t2_data2", log_data[base+2], 16'h07E0);
            check("t2_period01", log_t[base+1] - log_t[base], 5);
            check("t2_period12", log_t[base+2] - log_t[base+1], 5);
        end
        check("t2_csx_before_rel", lcd_csx, 0);
        tick();
        check("t2_csx_rel", lcd_csx, 1);
        repeat (3) tick();

        // overfill: six back-to-back words against a four-entry FIFO
        base = log_data.size();
        stall_seen = 0;
        for (int i = 0; i < 6; i++) push_word(i[0], 16'(16'h0100 + i), (i == 5));
        wait_log(base + 6, "t3_timeout");
        check("t3_stall_seen", stall_seen, 1);
        if (log_data.size() >= base + 6)
            for (int i = 0; i < 6; i++) check("t3_order", log_data[base+i], 16'(16'h0100 + i));
        repeat (3) tick();

        // HOLD gap between two words of one transaction
        base = log_data.size();
        push_word(1'b0, 16'h1234, 1'b0);
        repeat (12) tick();
        check("t4_hold_csx", lcd_csx, 0);
        check("t4_hold_wrx", lcd_wrx, 1);
        check("t4_hold_data", lcd_data_out, 16'h1234);
        check("t4_hold_dcx", lcd_dcx, 1);
        check("t4_one_strobe", log_data.size(), base + 1);
        repeat (8) tick();
        push_word(1'b0, 16'hABCD, 1'b1);
        wait_log(base + 2, "t4_timeout");
        if (log_data.size() >= base + 2) check("t4_second", log_data[base+1], 16'hABCD);
        check("t4_csx_before_rel", lcd_csx, 0);
        repeat (2) tick();
        check("t4_csx_rel", lcd_csx, 1);
        repeat (3) tick();

        // reset during WR_LOW of the second word
        base = log_data.size();
        bf = falls_seen;
        push_word(1'b1, 16'h0011, 1'b0);
        push_word(1'b0, 16'h0022, 1'b0);
        push_word(1'b0, 16'h0033, 1'b1);
        t = 0;
        while (falls_seen < bf + 2) begin
            @(negedge clk); #1;
            t++;
            if (t > 200) begin
                fail_now("t5_fall_timeout");
                break;
            end
        end
        tick();
        reset_n = 1'b0;
        tick();
        check("t5_wrx", lcd_wrx, 1);
        check("t5_csx", lcd_csx, 1);
        check("t5_lcd_reset", lcd_reset, 0);
        check("t5_in_ready", in_ready, 0);
        tick();
        reset_n = 1'b1;
        repeat (INIT_CYC + 6) tick();
        check("t5_no_extra_strobe", log_data.size(), base + 1);
        check("t5_idle_csx", lcd_csx, 1);
        check("t5_fifo_empty_ready", in_ready, 1);
        push_word(1'b1, 16'h0055, 1'b0);
        push_word(1'b0, 16'h0066, 1'b1);
        wait_log(base + 3, "t5_timeout");
        if (log_data.size() >= base + 3) begin
            check("t5_after_a", log_data[base+1], 16'h0055);
            check("t5_after_b", log_data[base+2], 16'h0066);
        end
        repeat (3) tick();

        // randomized stream
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
            push_word(1'($urandom_range(0, 1)), 16'($urandom),
                      ($urandom_range(0, 3) == 0) || (i == 1999));
        end
        wait_drain();
        repeat (3) tick();
        check("t6_final_csx", lcd_csx, 1);
        check("t6_final_rdx", lcd_rdx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
